octree_rom_arbiter: RTL
=======================

Name: octree_rom_arbiter

Overview:
- Shares one octant ROM port (synchronous read, 1-cycle latency, `dout` holds while `ren` low) between `NUM_REQ` ray-traversal units.
- Round-robin arbitration, valid/ready request and response handshakes, one outstanding read.
- Sits between the traversal cores and the octant ROM; drives the ROM's `addr1`/`ren` and presents its `dout1` to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDRESS_WIDTH, 32, ROM address width
- DATA_WIDTH, 32, ROM word width
- ROM_DEPTH, 38, number of valid ROM words (used only with bounds check)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses, requester i at bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- rsp_valid  out  NUM_REQ  response valid for requester i (one-hot or zero)
- rsp_ready  in  NUM_REQ  requester i consumes response
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters
- rsp_err  out  1  address out of range (bounds feature only)
- rom_addr  out  ADDRESS_WIDTH  to ROM addr1
- rom_ren  out  1  to ROM ren
- rom_dout  in  DATA_WIDTH  from ROM dout1

Behaviour:
- Clock is `clk`; reset is `rst_n`, synchronous, active-low. While `rst_n`=0 at an edge:
  - state <= IDLE
  - rr_ptr <= NUM_REQ-1
  - owner cleared
- After reset, and during any cycle in IDLE with no request: `req_ready`=0, `rsp_valid`=0, `rom_ren`=0, `rom_addr`=0, `rsp_err`=0.
- States:
  - IDLE: no read outstanding.
  - RESP: read data held for `owner`.
- Accept window (`acc`) is open when state=IDLE, or when state=RESP and `rsp_ready[owner]`=1.
- Winner: the first i with `req_valid[i]`=1, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
- In an accept window with a winner (all combinational in that cycle):
  - `req_ready[winner]`=1
  - `rom_ren`=1
  - `rom_addr`=`req_addr[winner]`
- At the next edge after an accept: owner <= winner, rr_ptr <= winner, state <= RESP.
- RESP:
  - `rsp_valid[owner]`=1
  - `rsp_data`=`rom_dout`, which is stable because the ROM holds its output while `rom_ren`=0
- Leaving RESP: if `rsp_ready[owner]`=1 and no new winner, state <= IDLE. If a new winner is accepted in the same cycle, state stays RESP with the new owner (back-to-back, 1 read/cycle).
- Latency: request accepted in cycle T gives `rsp_valid` and data in cycle T+1.
- Response backpressure: `rsp_valid` and `rsp_data` stay stable until `rsp_ready[owner]`. No new ROM read is issued meanwhile.
- `req_ready` may depend combinationally on `req_valid`. Requesters must not gate `req_valid` on `req_ready`.
- A requester holding `req_valid` may not change `req_addr` until accepted. Deasserting `req_valid` before acceptance withdraws the request without error.
- `rsp_ready` for non-owners is ignored.
- Reset asserted mid-RESP: the pending response is discarded and no `rsp_valid` pulse follows.
- Fairness: any requester continuously valid is granted within NUM_REQ accepts.
- All values of `req_addr` are passed to the ROM unchanged unless the bounds feature is enabled.

Optional Feature:
- Macro: OCTREE_ARB_BOUNDS_EN.
- Defined:
  - Winner address >= ROM_DEPTH is still accepted (`req_ready`=1) but `rom_ren` stays 0.
  - Response arrives at the same latency with `rsp_data`=0 and `rsp_err`=1, registered with the owner.
  - `rsp_err`=0 for in-range reads.
- Undefined: `rsp_err` tied 0; no range compare; every accepted address drives `rom_ren`=1.

Test Plan:
- ROM model mem[i]=32'hA000_0000+i. Reset, then req0 valid addr 5 at cycle 0 -> `req_ready`=01, `rom_ren`=1, `rom_addr`=5 at cycle 0; `rsp_valid`=01, `rsp_data`=A000_0005 at cycle 1.
- req0 and req1 both continuously valid (addr 3 and 7), `rsp_ready`=11 always -> grants alternate 0,1,0,1; `rsp_data` sequence A000_0003, A000_0007, ... with one response every cycle.
- req1 valid addr 9, `rsp_ready[1]`=0 for 4 cycles -> `rsp_valid`=10 and `rsp_data`=A000_0009 stable all 4 cycles; `rom_ren`=0; req0 valid meanwhile is not accepted until the cycle `rsp_ready[1]` rises.
- `rst_n` low for one cycle while in RESP -> next cycle `rsp_valid`=0, `rom_ren`=0; first post-reset grant goes to req0 when both requesters are valid.
- `OCTREE_ARB_BOUNDS_EN` defined, req0 addr 38 -> `req_ready`=01, `rom_ren`=0; next cycle `rsp_valid`=01, `rsp_data`=0, `rsp_err`=1. Then addr 37 -> `rsp_data`=A000_0025, `rsp_err`=0.
- NUM_REQ=4, all valid, `rsp_ready` all 1 -> grant order 0,1,2,3,0; dropping `req_valid[2]` before its turn yields order 0,1,3,0.

Source files
------------

// File: rtl/octree_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous octant ROM read port between NUM_REQ traversal units.
// Optional address bounds check: define OCTREE_ARB_BOUNDS_EN.
module octree_rom_arbiter #(
   parameter int unsigned NUM_REQ       = 2,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ROM_DEPTH     = 38
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               rsp_valid,
   input  logic [NUM_REQ-1:0]               rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             rsp_err,
   output logic [ADDRESS_WIDTH-1:0]         rom_addr,
   output logic                             rom_ren,
   input  logic [DATA_WIDTH-1:0]            rom_dout
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || ROM_DEPTH == 0) begin : g_bad_cfg
      $error("octree_rom_arbiter: unsupported parameter set");
   end

   typedef enum logic {IDLE, RESP} state_t;

   state_t                   state;
   logic [PTR_W-1:0]         rr_ptr;
   logic [PTR_W-1:0]         owner;
   logic                     acc;
   logic                     found;
   logic                     grant;
   logic                     in_range;
   logic [PTR_W-1:0]         win;
   logic [ADDRESS_WIDTH-1:0] win_addr;

   // No accepts while reset is asserted, since the handshake would be lost.
   assign acc   = rst_n && ((state == IDLE) || rsp_ready[owner]);
   assign grant = acc && found;

   // Round-robin winner search starting just after the last grant.
   always_comb begin
      int unsigned      j;
      logic [PTR_W-1:0] idx;
      found    = 1'b0;
      win      = '0;
      win_addr = '0;
      j        = 0;
      idx      = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         j   = (32'(rr_ptr) + k) % NUM_REQ;
         idx = PTR_W'(j);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win == PTR_W'(i)) begin
            win_addr = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rom_ren   = 1'b0;
      rom_addr  = '0;
      if (grant) begin
         req_ready[win] = 1'b1;
         rom_ren        = in_range;
         rom_addr       = win_addr;
      end
      if (state == RESP) begin
         rsp_valid[owner] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= PTR_W'(NUM_REQ - 1);
         owner  <= '0;
      end else if (grant) begin
         state  <= RESP;
         owner  <= win;
         rr_ptr <= win;
      end else if (state == RESP && rsp_ready[owner]) begin
         state  <= IDLE;
      end
   end

`ifdef OCTREE_ARB_BOUNDS_EN
   localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(ROM_DEPTH);

   logic err_q;

   // Out-of-range reads skip the ROM and answer with zero data plus an error flag.
   assign in_range = (win_addr < DEPTH_A);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (grant) begin
         err_q <= !in_range;
      end
   end

   assign rsp_err  = (state == RESP) && err_q;
   assign rsp_data = ((state == RESP) && !err_q) ? rom_dout : '0;
`else
   assign in_range = 1'b1;
   assign rsp_err  = 1'b0;
   assign rsp_data = (state == RESP) ? rom_dout : '0;
`endif

endmodule
